// File: rtl/multi_ring_osc_if.sv
// Bundle of configuration, control and status signals for multi_ring_osc.
//   master: drives cfg_we/cfg_ch/cfg_half/cfg_burst, start, stop;
//           observes out, busy, done
//   slave : the oscillator block itself
interface multi_ring_osc_if #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned BURST_W = 8,
  parameter int unsigned CH_W    = 2
);
  logic               cfg_we;
  logic [CH_W-1:0]    cfg_ch;
  logic [CNT_W-1:0]   cfg_half;
  logic [BURST_W-1:0] cfg_burst;
  logic [NUM_CH-1:0]  start;
  logic [NUM_CH-1:0]  stop;
  logic [NUM_CH-1:0]  out;
  logic [NUM_CH-1:0]  busy;
  logic [NUM_CH-1:0]  done;

  modport master (
    output cfg_we, cfg_ch, cfg_half, cfg_burst, start, stop,
    input  out, busy, done
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_half, cfg_burst, start, stop,
    output out, busy, done
  );
endinterface

// File: rtl/multi_ring_osc.sv
// Bank of NUM_CH independent programmable square-wave generators.
// Each channel holds a half-period and a burst length. A start launches a run
// that emits high/low phases of half_l cycles each; with a non-zero burst the
// run ends after burst_l high pulses and pulses done, otherwise it free-runs
// until stop.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - multi_ring_osc_if.slave: cfg write port, start/stop requests,
//          out/busy/done status per channel
module multi_ring_osc #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned BURST_W = 8,
  parameter int unsigned CH_W    = 2
) (
  input logic                  clk,
  input logic                  rst,
  multi_ring_osc_if.slave      bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  logic [NUM_CH-1:0] out_vec;
  logic [NUM_CH-1:0] busy_vec;
  logic [NUM_CH-1:0] done_vec;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   half_l_q, half_l_d;
    logic [BURST_W-1:0] per_q, per_d;
    logic [BURST_W-1:0] burst_l_q, burst_l_d;
    logic               out_q, out_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   half_cfg_q;
    logic [BURST_W-1:0] burst_cfg_q;
    logic [BURST_W-1:0] per_inc;
    logic               cfg_hit;

    // Channel indices outside the bank never match, so such writes are dropped.
    assign cfg_hit = bus.cfg_we && (bus.cfg_ch == CH_W'(c));
    assign per_inc = per_q + BURST_W'(1);

    // Config registers are independent of the run state; a running channel
    // keeps its latched half_l/burst_l copies.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        half_cfg_q  <= CNT_W'(1);
        burst_cfg_q <= '0;
      end else if (cfg_hit) begin
        half_cfg_q  <= bus.cfg_half;
        burst_cfg_q <= bus.cfg_burst;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q   <= StIdle;
        cnt_q     <= '0;
        half_l_q  <= CNT_W'(1);
        per_q     <= '0;
        burst_l_q <= '0;
        out_q     <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        half_l_q  <= half_l_d;
        per_q     <= per_d;
        burst_l_q <= burst_l_d;
        out_q     <= out_d;
        done_q    <= done_d;
      end
    end

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      half_l_d  = half_l_q;
      per_d     = per_q;
      burst_l_d = burst_l_q;
      out_d     = out_q;
      done_d    = 1'b0;
      unique case (state_q)
        StIdle: begin
          // stop has priority over a simultaneous start
          if (bus.start[c] && !bus.stop[c]) begin
            state_d   = StRun;
            out_d     = 1'b1;
            cnt_d     = '0;
            per_d     = '0;
            half_l_d  = (half_cfg_q == '0) ? CNT_W'(1) : half_cfg_q;
            burst_l_d = burst_cfg_q;
          end
        end
        StRun: begin
          if (bus.stop[c]) begin
            state_d = StIdle;
            out_d   = 1'b0;
            cnt_d   = '0;
            per_d   = '0;
          end else if (cnt_q == half_l_q - CNT_W'(1)) begin
            cnt_d = '0;
            if (out_q) begin
              out_d = 1'b0;
            end else if ((burst_l_q != '0) && (per_inc == burst_l_q)) begin
              // This rising edge would start pulse burst_l+1: end the burst.
              state_d = StIdle;
              out_d   = 1'b0;
              per_d   = '0;
              done_d  = 1'b1;
            end else begin
              out_d = 1'b1;
              per_d = per_inc;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end

    assign out_vec[c]  = out_q;
    assign busy_vec[c] = (state_q == StRun);
    assign done_vec[c] = done_q;
  end

  assign bus.out  = out_vec;
  assign bus.busy = busy_vec;
  assign bus.done = done_vec;

endmodule

// File: tb/tb_multi_ring_osc.sv
module tb_multi_ring_osc;
  localparam int unsigned NumCh  = 4;
  localparam int unsigned CntW   = 16;
  localparam int unsigned BurstW = 8;
  localparam int unsigned ChW    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_ring_osc_if #(
    .NUM_CH (NumCh),
    .CNT_W  (CntW),
    .BURST_W(BurstW),
    .CH_W   (ChW)
  ) bus ();

  multi_ring_osc #(
    .NUM_CH (NumCh),
    .CNT_W  (CntW),
    .BURST_W(BurstW),
    .CH_W   (ChW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    int         at;
    logic [3:0] mask;
    logic [3:0] o;
    logic [3:0] b;
    logic [3:0] d;
    int         tag;
  } exp_t;

  exp_t expq[$];

  task automatic check(input int tag, input logic [11:0] act, input logic [11:0] req,
                       input logic [11:0] m);
    total++;
    if ((act & m) !== (req & m)) begin
      bad++;
      $display("FAIL t%0d cyc%0d {out,busy,done}: got %b want %b mask %b",
               tag, cyc, act, req, m);
    end
  endtask

  // Scoreboard insert, kept sorted by target cycle.
  task automatic push(input int at, input logic [3:0] m, input logic [3:0] o,
                      input logic [3:0] b, input logic [3:0] d, input int tag);
    exp_t e;
    int   i;
    e.at = at; e.mask = m; e.o = o; e.b = b; e.d = d; e.tag = tag;
    i = expq.size();
    while (i > 0 && expq[i-1].at > at) i--;
    expq.insert(i, e);
  endtask

  // Model of one run started on edge e: out high while (k/h) is even; a burst
  // of b pulses ends on edge e+2hb with a single done cycle.
  task automatic expect_run(input int ch, input int e, input int h, input int b,
                            input int nk, input int tag);
    logic [3:0] m;
    logic       o, bz, d;
    m = 4'b0001 << ch;
    for (int k = 0; k < nk; k++) begin
      if (b != 0 && k >= 2 * h * b) begin
        o = 1'b0; bz = 1'b0; d = (k == 2 * h * b);
      end else begin
        o = ((k / h) % 2 == 0); bz = 1'b1; d = 1'b0;
      end
      push(e + k, m, {4{o}} & m, {4{bz}} & m, {4{d}} & m, tag);
    end
  endtask

  task automatic expect_idle(input logic [3:0] m, input int e, input int n, input int tag);
    for (int k = 0; k < n; k++) push(e + k, m, 4'h0, 4'h0, 4'h0, tag);
  endtask

  // Monitor: compare every scoreboard entry due at this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (expq.size() != 0 && expq[0].at <= cyc) begin
      e = expq.pop_front();
      check(e.tag, {bus.out, bus.busy, bus.done}, {e.o, e.b, e.d}, {e.mask, e.mask, e.mask});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] st, input logic [3:0] sp);
    bus.start = st;
    bus.stop  = sp;
    tick();
    bus.start = '0;
    bus.stop  = '0;
  endtask

  task automatic cfg(input int ch, input int half, input int burst);
    bus.cfg_we    = 1'b1;
    bus.cfg_ch    = ChW'(ch);
    bus.cfg_half  = CntW'(half);
    bus.cfg_burst = BurstW'(burst);
    tick();
    bus.cfg_we = 1'b0;
  endtask

  initial begin
    int e;
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_half = '0; bus.cfg_burst = '0;
    bus.start = '0; bus.stop = '0;

    // Reset state
    expect_idle(4'hF, 1, 2, 0);
    tick(); tick();
    rst = 1'b0;
    expect_idle(4'hF, cyc + 1, 1, 0);
    tick();

    // Defaults on ch0: period 2, others quiet
    e = cyc + 1;
    expect_run(0, e, 1, 0, 8, 1);
    expect_idle(4'hE, e, 8, 1);
    pulse(4'h1, 4'h0);
    repeat (7) tick();
    expect_idle(4'h1, cyc + 1, 2, 1);
    pulse(4'h0, 4'h1);
    tick();

    // ch1 half=3 burst=2: two pulses then done
    cfg(1, 3, 2);
    e = cyc + 1;
    expect_run(1, e, 3, 2, 14, 2);
    pulse(4'h2, 4'h0);
    repeat (14) tick();

    // ch2 half=0 treated as 1, free-run, stop after 7 cycles
    cfg(2, 0, 0);
    e = cyc + 1;
    expect_run(2, e, 1, 0, 7, 3);
    pulse(4'h4, 4'h0);
    repeat (6) tick();
    expect_idle(4'h4, cyc + 1, 2, 3);
    pulse(4'h0, 4'h4);
    tick();

    // ch3: start+stop together stays idle; start during run is ignored
    cfg(3, 2, 0);
    expect_idle(4'h8, cyc + 1, 2, 4);
    pulse(4'h8, 4'h8);
    tick();
    e = cyc + 1;
    expect_run(3, e, 2, 0, 12, 5);
    pulse(4'h8, 4'h0);
    tick();
    pulse(4'h8, 4'h0);
    repeat (9) tick();
    expect_idle(4'h8, cyc + 1, 2, 5);
    pulse(4'h0, 4'h8);
    tick();

    // Reconfigure ch1 mid-run: current run keeps half=3, next uses half=5
    e = cyc + 1;
    expect_run(1, e, 3, 2, 14, 6);
    pulse(4'h2, 4'h0);
    cfg(1, 5, 2);
    repeat (13) tick();
    e = cyc + 1;
    expect_run(1, e, 5, 2, 22, 7);
    pulse(4'h2, 4'h0);
    repeat (22) tick();

    // Async reset in the middle of a high phase
    e = cyc + 1;
    expect_run(1, e, 5, 2, 2, 8);
    pulse(4'h2, 4'h0);
    tick(); tick();
    #2;
    check(8, {8'h0, bus.out}, {8'h0, 4'h2}, 12'h002);
    rst = 1'b1;
    #1;
    check(8, {bus.out, bus.busy, bus.done}, 12'h000, 12'hFFF);
    expect_idle(4'hF, cyc + 1, 1, 8);
    tick(); tick();
    rst = 1'b0;
    tick();
    // Config back to half=1, burst=0
    e = cyc + 1;
    expect_run(1, e, 1, 0, 6, 9);
    pulse(4'h2, 4'h0);
    repeat (5) tick();
    expect_idle(4'h2, cyc + 1, 1, 9);
    pulse(4'h0, 4'h2);
    tick();

    for (int i = 0; i < 50 && expq.size() != 0; i++) tick();
    if (expq.size() != 0) begin
      bad++;
      total++;
      $display("FAIL drain: got %0d pending want 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_ring_osc.md
MULTI_RING_OSC -- requirements
Module: multi_ring_osc

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent oscillator channels.
REQ-002 Parameter CNT_W, default 16: width of the half-period count.
REQ-003 Parameter BURST_W, default 8: width of the burst-length count.
REQ-004 Parameter CH_W, default 2: width of the channel index, equal to max(1, clog2(NUM_CH)).
REQ-005 clk  input  1  single system clock, rising-edge active.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 cfg_we  input  1  configuration write strobe, one cycle.
REQ-008 cfg_ch  input  CH_W  channel addressed by cfg_we.
REQ-009 cfg_half  input  CNT_W  half-period in clk cycles; 0 is treated as 1.
REQ-010 cfg_burst  input  BURST_W  number of full periods per run; 0 means free-run.
REQ-011 start  input  NUM_CH  per-channel start request, sampled each edge.
REQ-012 stop  input  NUM_CH  per-channel stop request, sampled each edge.
REQ-013 out  output  NUM_CH  per-channel oscillator output, registered.
REQ-014 busy  output  NUM_CH  per-channel high while the channel is in RUN.
REQ-015 done  output  NUM_CH  per-channel one-cycle pulse when a burst completes.

Function
REQ-016 Each channel shall hold config registers half_cfg (CNT_W) and burst_cfg (BURST_W), written on a clk edge with cfg_we=1 at index cfg_ch.
REQ-017 A cfg_we with cfg_ch >= NUM_CH shall be ignored.
REQ-018 Each channel shall run a two-state FSM: IDLE and RUN; busy shall equal (state==RUN).
REQ-019 IDLE->RUN on an edge with start[c]=1 and stop[c]=0; on that edge out[c]<=1, cnt<=0, per_cnt<=0, half_l<=max(half_cfg,1), burst_l<=burst_cfg.
REQ-020 In RUN, each edge with cnt==half_l-1 shall set cnt<=0 and toggle out[c]; otherwise cnt<=cnt+1.
REQ-021 Resulting waveform: out high for half_l cycles, then low for half_l cycles; period 2*half_l; first high phase begins the cycle after start is sampled.
REQ-022 On each low-to-high toggle, per_cnt shall increment by 1 (BURST_W-bit).
REQ-023 If burst_l!=0 and a low-to-high toggle would make per_cnt equal burst_l, the channel shall instead go to IDLE, hold out[c]=0, and pulse done[c] for exactly one cycle; exactly burst_l high pulses are produced.
REQ-024 If burst_l==0, the channel shall run until stop; per_cnt shall wrap silently.
REQ-025 stop[c]=1 in RUN shall force IDLE and out[c]<=0 on that edge, with no done pulse.
REQ-026 start[c] while in RUN shall be ignored (no restart).
REQ-027 start[c] and stop[c] both high on the same edge: stop wins; the channel ends in IDLE.
REQ-028 cfg_we to a running channel shall update half_cfg/burst_cfg only; the current run shall continue with half_l/burst_l unchanged.
REQ-029 Channels shall be fully independent; activity on one channel shall not affect any other.
REQ-030 done[c] in the same edge as a new start[c] shall be handled as follows: start is sampled in the next cycle only (IDLE is entered first).

Reset
REQ-031 rst=1 shall immediately, without waiting for clk, force all channels to IDLE with out=0, busy=0, done=0, cnt=0, per_cnt=0.
REQ-032 Reset shall set half_cfg=1 and burst_cfg=0 for all channels.
REQ-033 Reset asserted mid-run shall abort the run with no done pulse; after release, a new start is required.

Verification
REQ-034 Bench: reset, then start[0] with defaults -> out[0] toggles every cycle (period 2); busy[0]=1; other channels stay 0.
REQ-035 Bench: cfg ch1 half=3, burst=2, then start[1] -> out[1] 3 high, 3 low, 3 high, 3 low; then IDLE; done[1] one-cycle pulse; busy[1] falls.
REQ-036 Bench: cfg ch2 half=0, burst=0, start, then stop after 7 cycles -> half treated as 1; out[2] forced 0 on stop edge; no done.
REQ-037 Bench: start and stop same edge on ch3 -> stays IDLE, out[3]=0; start during RUN -> phase unchanged.
REQ-038 Bench: during RUN of ch1 (half=3), write half=5 -> current run keeps period 6; next start uses period 10.
REQ-039 Bench: assert rst asynchronously mid-high-phase -> out, busy, done go 0 before the next clk edge; half_cfg reads back as 1 on the next run.
